// File: rtl/cam_result_reader_pkg.sv
// Shared definitions for the CAM result-read sequencer and its range checker.
package cam_result_reader_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_CAPT = 3'd2,
    S_SEND = 3'd3,
    S_DONE = 3'd4
  } state_e;

  localparam logic MODE_ROW = 1'b0;
  localparam logic MODE_COL = 1'b1;

endpackage

// File: rtl/cam_rd_range_check.sv
// Combinational readout range check: effective vector count and bounds validity.
module cam_rd_range_check
  import cam_result_reader_pkg::*;
#(
  parameter int DATA_WIDTH     = 4,
  parameter int DATA_DEPTH     = 4,
  parameter int ADDR_WIDTH_CAM = 8
) (
  input  logic                      col_mode_i,
  input  logic [ADDR_WIDTH_CAM-1:0] start_idx_i,
  input  logic [ADDR_WIDTH_CAM-1:0] count_i,
  output logic [ADDR_WIDTH_CAM:0]   eff_count_o,
  output logic                      range_ok_o
);

  localparam int LW = ADDR_WIDTH_CAM + 1;

  logic [ADDR_WIDTH_CAM:0]   limit;
  logic [ADDR_WIDTH_CAM+1:0] end_idx;

  // One extra bit on the end index so start_idx + count can never wrap.
  always_comb begin
    limit       = (col_mode_i == MODE_COL) ? LW'(DATA_WIDTH) : LW'(DATA_DEPTH);
    eff_count_o = (count_i == '0) ? limit : {1'b0, count_i};
    end_idx     = {2'b00, start_idx_i} + {1'b0, eff_count_o};
    range_ok_o  = ({1'b0, start_idx_i} < limit) && (end_idx <= {1'b0, limit});
  end

endmodule

// File: rtl/cam_result_reader.sv
// Walks the CAM R array by row or column and streams each vector to memory.
module cam_result_reader
  import cam_result_reader_pkg::*;
#(
  parameter int DATA_WIDTH     = 4,
  parameter int DATA_DEPTH     = 4,
  parameter int ADDR_WIDTH_CAM = 8,
  parameter int ADDR_WIDTH_MEM = 16,
  parameter int OUT_WIDTH      = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      col_mode,
  input  logic [ADDR_WIDTH_CAM-1:0] start_idx,
  input  logic [ADDR_WIDTH_CAM-1:0] count,
  input  logic [ADDR_WIDTH_MEM-1:0] base_addr,
  input  logic                      abort,
  output logic [ADDR_WIDTH_CAM-1:0] addr_output_Row_R,
  output logic [ADDR_WIDTH_CAM-1:0] addr_output_Col_R,
  input  logic [DATA_WIDTH-1:0]     Q_out_R_row,
  input  logic [DATA_DEPTH-1:0]     Q_out_R_col,
  output logic [OUT_WIDTH-1:0]      data_out,
  output logic [ADDR_WIDTH_MEM-1:0] addr_out,
  output logic                      data_valid,
  input  logic                      data_ready,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic [2:0]                dbg_state_o
);

  localparam logic [ADDR_WIDTH_CAM:0] REM_ONE = {{ADDR_WIDTH_CAM{1'b0}}, 1'b1};

  state_e                    state_q;
  logic                      mode_q;
  logic [ADDR_WIDTH_CAM-1:0] idx_q;
  logic [ADDR_WIDTH_CAM:0]   rem_q;
  logic [ADDR_WIDTH_MEM-1:0] maddr_q;
  logic [ADDR_WIDTH_CAM-1:0] row_addr_q;
  logic [ADDR_WIDTH_CAM-1:0] col_addr_q;
  logic [OUT_WIDTH-1:0]      data_q;
  logic [ADDR_WIDTH_MEM-1:0] addr_out_q;
  logic                      valid_q;
  logic                      busy_q;
  logic                      done_q;
  logic                      err_q;

  logic [ADDR_WIDTH_CAM:0]   eff_count;
  logic                      range_ok;
  logic [OUT_WIDTH-1:0]      cap_d;
  logic [ADDR_WIDTH_CAM-1:0] idx_inc;

  cam_rd_range_check #(
    .DATA_WIDTH    (DATA_WIDTH),
    .DATA_DEPTH    (DATA_DEPTH),
    .ADDR_WIDTH_CAM(ADDR_WIDTH_CAM)
  ) u_range (
    .col_mode_i (col_mode),
    .start_idx_i(start_idx),
    .count_i    (count),
    .eff_count_o(eff_count),
    .range_ok_o (range_ok)
  );

  assign idx_inc = idx_q + 1'b1;

  always_comb begin
    cap_d = '0;
    if (mode_q == MODE_COL) cap_d[DATA_DEPTH-1:0] = Q_out_R_col;
    else                    cap_d[DATA_WIDTH-1:0] = Q_out_R_row;
  end

  // Output handshake: a word transfers on a rising edge where data_valid && data_ready;
  // once raised, data_valid/data_out/addr_out hold until that edge (or abort/reset).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      mode_q     <= MODE_ROW;
      idx_q      <= '0;
      rem_q      <= '0;
      maddr_q    <= '0;
      row_addr_q <= '0;
      col_addr_q <= '0;
      data_q     <= '0;
      addr_out_q <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (state_q != S_IDLE && abort) begin
        state_q <= S_IDLE;
        valid_q <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start) begin
              if (!range_ok) begin
                err_q <= 1'b1;
              end else begin
                mode_q  <= col_mode;
                idx_q   <= start_idx;
                rem_q   <= eff_count;
                maddr_q <= base_addr;
                busy_q  <= 1'b1;
                state_q <= S_ADDR;
                // The address is registered here so it is already stable in ADDR.
                if (col_mode == MODE_COL) begin
                  col_addr_q <= start_idx;
                  row_addr_q <= '0;
                end else begin
                  row_addr_q <= start_idx;
                  col_addr_q <= '0;
                end
              end
            end
          end
          S_ADDR: state_q <= S_CAPT;
          S_CAPT: begin
            data_q     <= cap_d;
            addr_out_q <= maddr_q;
            valid_q    <= 1'b1;
            state_q    <= S_SEND;
          end
          S_SEND: begin
            if (data_ready) begin
              valid_q <= 1'b0;
              rem_q   <= rem_q - REM_ONE;
              if (rem_q == REM_ONE) begin
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= S_DONE;
              end else begin
                idx_q   <= idx_inc;
                maddr_q <= maddr_q + 1'b1;
                if (mode_q == MODE_COL) col_addr_q <= idx_inc;
                else                    row_addr_q <= idx_inc;
                state_q <= S_ADDR;
              end
            end
          end
          S_DONE:  state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign addr_output_Row_R = row_addr_q;
  assign addr_output_Col_R = col_addr_q;
  assign data_out          = data_q;
  assign addr_out          = addr_out_q;
  assign data_valid        = valid_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign err               = err_q;
  assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_cam_result_reader.sv
// Directed bench for cam_result_reader with a clocked CAM read model and a word scoreboard.
module tb_cam_result_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        col_mode = 1'b0;
  logic [7:0]  start_idx = '0;
  logic [7:0]  count = '0;
  logic [15:0] base_addr = '0;
  logic        abort = 1'b0;
  logic        data_ready = 1'b0;
  logic [7:0]  addr_output_Row_R, addr_output_Col_R;
  logic [3:0]  Q_out_R_row = '0;
  logic [3:0]  Q_out_R_col = '0;
  logic [3:0]  data_out;
  logic [15:0] addr_out;
  logic        data_valid, busy, done, err;
  logic [2:0]  dbg_state;

  cam_result_reader dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .col_mode         (col_mode),
    .start_idx        (start_idx),
    .count            (count),
    .base_addr        (base_addr),
    .abort            (abort),
    .addr_output_Row_R(addr_output_Row_R),
    .addr_output_Col_R(addr_output_Col_R),
    .Q_out_R_row      (Q_out_R_row),
    .Q_out_R_col      (Q_out_R_col),
    .data_out         (data_out),
    .addr_out         (addr_out),
    .data_valid       (data_valid),
    .data_ready       (data_ready),
    .busy             (busy),
    .done             (done),
    .err              (err),
    .dbg_state_o      (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // CAM R array model with one-cycle read latency.
  logic [3:0] r_mem [4];
  always @(posedge clk) begin
    Q_out_R_row <= r_mem[addr_output_Row_R[1:0]];
    for (int i = 0; i < 4; i++) Q_out_R_col[i] <= r_mem[i][addr_output_Col_R[1:0]];
  end

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic [19:0] exp_q[$];
  int          hs_cyc[$];
  int          hs_total = 0;
  int          done_cyc = 0;
  logic        row_zero_chk = 1'b0;
  logic        p_hold = 1'b0, p_hs = 1'b0, p_done = 1'b0;
  logic [3:0]  p_data = '0;
  logic [15:0] p_addr = '0;

  always @(negedge clk) begin
    logic [19:0] e;
    if (rst_n) begin
      if (p_hold) begin
        check("hold_valid", data_valid, 1);
        check("hold_data", data_out, p_data);
        check("hold_addr", addr_out, p_addr);
      end
      if (p_hs) check("gap_after_hs", data_valid, 0);
      if (p_done) check("done_width", done, 0);
      if (done) check("busy_at_done", busy, 0);
      if (data_valid) check("busy_with_valid", busy, 1);
      if (row_zero_chk) check("row_addr_zero", addr_output_Row_R, 0);
      if (data_valid && data_ready) begin
        hs_total++;
        hs_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("word_not_expected", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check("word_data", data_out, e[3:0]);
          check("word_addr", addr_out, e[19:4]);
        end
      end
      if (done) done_cyc = cyc;
    end
    p_hold = rst_n && data_valid && !data_ready && !abort;
    p_hs   = rst_n && data_valid && data_ready;
    p_done = rst_n && done;
    p_data = data_out;
    p_addr = addr_out;
  end

  // ---------------- driver tasks ----------------
  int st_cyc = 0;

  task automatic start_run(input logic mode, input logic [7:0] sidx, input logic [7:0] cnt,
                           input logic [15:0] base);
    @(posedge clk); #1;
    start = 1'b1; col_mode = mode; start_idx = sidx; count = cnt; base_addr = base;
    @(negedge clk);
    st_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < budget);
    check("done_timeout", done, 1);
    #1;
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!data_valid && n < budget);
    check("valid_timeout", data_valid, 1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, data_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_state"}, dbg_state, 0);
  endtask

  // ---------------- stimulus ----------------
  int hs_base;

  initial begin
    r_mem[0] = 4'h3; r_mem[1] = 4'hA; r_mem[2] = 4'h5; r_mem[3] = 4'hF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_data", data_out, 0);
    check("rst_addr", addr_out, 0);
    check("rst_row", addr_output_Row_R, 0);
    check("rst_col", addr_output_Col_R, 0);
    check("rst_err", err, 0);
    check_idle_outputs("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Full row readout
    data_ready = 1'b1;
    hs_cyc.delete();
    exp_q.push_back({16'h0100, 4'h3});
    exp_q.push_back({16'h0101, 4'hA});
    exp_q.push_back({16'h0102, 4'h5});
    exp_q.push_back({16'h0103, 4'hF});
    start_run(1'b0, 8'd0, 8'd0, 16'h0100);
    wait_done(100);
    check("row_hs_count", hs_cyc.size(), 4);
    if (hs_cyc.size() == 4) begin
      check("row_first_latency", hs_cyc[0] - st_cyc, 3);
      for (int k = 1; k < 4; k++) check("row_spacing", hs_cyc[k] - hs_cyc[k-1], 3);
      check("row_done_cycle", done_cyc - hs_cyc[3], 1);
    end
    check("row_leftover", exp_q.size(), 0);

    // Column readout of cols 1..2
    r_mem[0] = 4'b0001; r_mem[1] = 4'b0010; r_mem[2] = 4'b0100; r_mem[3] = 4'b1000;
    exp_q.push_back({16'h0200, 4'b0010});
    exp_q.push_back({16'h0201, 4'b0100});
    start_run(1'b1, 8'd1, 8'd2, 16'h0200);
    row_zero_chk = 1'b1;
    wait_done(100);
    row_zero_chk = 1'b0;
    check("col_last_col_addr", addr_output_Col_R, 2);
    check("col_leftover", exp_q.size(), 0);

    // Backpressure on word 2
    r_mem[0] = 4'h6; r_mem[1] = 4'h9; r_mem[2] = 4'hC; r_mem[3] = 4'h1;
    exp_q.push_back({16'h0300, 4'h6});
    exp_q.push_back({16'h0301, 4'h9});
    exp_q.push_back({16'h0302, 4'hC});
    exp_q.push_back({16'h0303, 4'h1});
    hs_base = hs_total;
    start_run(1'b0, 8'd0, 8'd0, 16'h0300);
    wait_valid(50);
    @(posedge clk); #1;
    data_ready = 1'b0;
    wait_valid(50);
    repeat (5) @(posedge clk);
    #1;
    data_ready = 1'b1;
    wait_done(100);
    check("bp_hs_total", hs_total - hs_base, 4);
    check("bp_leftover", exp_q.size(), 0);

    // Range errors
    start_run(1'b0, 8'd3, 8'd2, 16'h0000);
    @(negedge clk);
    check("err1_pulse", err, 1);
    check("err1_busy", busy, 0);
    repeat (3) begin
      @(negedge clk);
      check("err1_after", err, 0);
      check_idle_outputs("err1");
    end
    start_run(1'b0, 8'd4, 8'd1, 16'h0000);
    @(negedge clk);
    check("err2_pulse", err, 1);
    check("err2_busy", busy, 0);
    @(negedge clk);
    check("err2_after", err, 0);

    // Abort while holding word 1
    r_mem[0] = 4'h3; r_mem[1] = 4'hA; r_mem[2] = 4'h5; r_mem[3] = 4'hF;
    data_ready = 1'b0;
    start_run(1'b0, 8'd0, 8'd0, 16'h0400);
    wait_valid(50);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    check_idle_outputs("abort");
    repeat (3) begin
      @(negedge clk);
      check("abort_no_done", done, 0);
    end
    data_ready = 1'b1;
    exp_q.push_back({16'h0500, 4'h5});
    start_run(1'b0, 8'd2, 8'd1, 16'h0500);
    wait_done(100);
    check("post_abort_leftover", exp_q.size(), 0);

    // Reset during CAPT
    start_run(1'b0, 8'd0, 8'd0, 16'h0700);
    begin
      int n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (dbg_state != 3'd2 && n < 20);
      check("capt_reached", dbg_state, 2);
    end
    rst_n = 1'b0;
    #1;
    check("arst_data", data_out, 0);
    check("arst_addr", addr_out, 0);
    check("arst_row", addr_output_Row_R, 0);
    check_idle_outputs("arst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.push_back({16'h0600, 4'hA});
    exp_q.push_back({16'h0601, 4'h5});
    start_run(1'b0, 8'd1, 8'd2, 16'h0600);
    wait_done(100);
    check("post_rst_leftover", exp_q.size(), 0);

    // Memory address wrap
    exp_q.push_back({16'hFFFF, 4'h3});
    exp_q.push_back({16'h0000, 4'hA});
    start_run(1'b0, 8'd0, 8'd2, 16'hFFFF);
    wait_done(100);
    check("wrap_leftover", exp_q.size(), 0);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
